uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Parametrised UART command decoder that sits between the UART2 receive/transmit byte interface and a bank of NUM_CH DAC channel controllers. It parses multi-byte framed commands (start / pause / stop / set-frequency, per channel or broadcast), updates registered per-channel control and frequency words, and returns a one-byte status response through the UART transmitter. It replaces the single-character, single-channel decode in the top level. It adds framing, validation, inter-byte timeout and acknowledgement.

## Interface
- NUM_CH, 2, number of DAC channels (1..10)
- FREQ_W, 8, frequency word width per channel; multiple of 8, 8..32; FREQ_BYTES = FREQ_W/8
- FREQ_DEFAULT, 108, reset value of every channel's frequency word
- TIMEOUT_CYC, 1_000_000, maximum ipClk cycles allowed between bytes of one frame

Ports:
- ipClk  in  1  system clock; single clock domain
- ipReset  in  1  synchronous, active-high reset
- ipRxData  in  8  received byte from UART2
- ipRxValid  in  1  one-cycle strobe, ipRxData valid
- opTxData  out  8  response byte to UART2
- opTxSend  out  1  one-cycle transmit request
- ipTxBusy  in  1  UART2 transmitter busy
- opControl  out  2*NUM_CH  channel n at [2n+1:2n]: 01 start, 10 pause, 00 stop
- opFreq  out  FREQ_W*NUM_CH  channel n at [FREQ_W*(n+1)-1:FREQ_W*n]
- opDrop  out  1  one-cycle pulse when a received byte is discarded

## Operation
- Frame: CMD, CH, then FREQ_BYTES data bytes (big-endian) only when CMD = 'f'.
- CMD: 's' → 01, 'p' → 10, 'x' → 00, 'f' → load frequency. Any other CMD byte immediately produces response 'E' and returns to IDLE.
- CH: ASCII '0'..('0'+NUM_CH-1) selects one channel; '*' selects all channels. Any other value → 'E', no data bytes consumed.
- 'f' value of 0 → 'E', registers unchanged.
- Success → response 'K'. Timeout → response 'T'. Any error or timeout leaves all registers unchanged.
- Unselected channels are never modified.
- States:
  - IDLE: a byte is taken as CMD → GET_CH, or → RESP('E').
  - GET_CH: CH byte valid → GET_DATA for 'f', else APPLY. Invalid CH → RESP('E').
  - GET_DATA: shifts bytes into an FREQ_W accumulator; after the last byte → APPLY.
  - APPLY: one cycle; writes the registers or selects 'E' → RESP.
  - RESP: waits for ipTxBusy = 0, pulses opTxSend → IDLE.
- Timeout counter: cleared on every accepted byte and on entry to GET_CH. Counts only in GET_CH and GET_DATA. Reaching TIMEOUT_CYC-1 → RESP('T').
- A byte arriving in APPLY or RESP is discarded and opDrop pulses; it is not parsed as a new CMD.

## Timing
- Reset values (any state):
  - opControl = all 0 (all channels stopped).
  - opFreq = FREQ_DEFAULT in every channel.
  - opTxSend = 0, opTxData = 0x00, opDrop = 0.
  - State = IDLE; timeout counter = 0; accumulator = 0.
- Reset mid-frame discards the partial frame. Next byte after reset is a CMD.
- Final frame byte strobed at cycle N:
  - APPLY at N+1.
  - opControl/opFreq update visible at N+2.
  - opTxSend earliest at N+2 (if ipTxBusy = 0 at N+1), opTxData valid in the same cycle.
- Invalid CMD/CH byte at cycle N: opTxSend earliest at N+2.
- opTxSend is high for exactly one cycle per frame. It is never asserted while ipTxBusy = 1 on the preceding cycle. opTxData holds the response until the next response.
- ipRxValid and timeout terminal count in the same cycle: the byte wins and the counter clears.
- Timeout: no byte for TIMEOUT_CYC cycles after the last accepted byte → RESP('T').
- Broadcast write updates all channels in the same cycle.
- opDrop is high in the cycle after the discarded byte's strobe.

## Test plan
Run with NUM_CH=2, FREQ_W=16, FREQ_DEFAULT=108, TIMEOUT_CYC=1000 unless noted.
- Reset, then frame 's','1' → opControl = 4'b0100, opFreq = {108,108}, single opTxSend with 'K' two cycles after the '1' strobe.
- Frame 'f','0',0x00,0x2A → ch0 freq = 42, ch1 = 108, 'K'. Frame 'f','0',0x00,0x00 → 'E', freqs unchanged.
- Byte 'z' → 'E' with no further bytes consumed. Frame 's','9' → 'E', opControl unchanged. Frame 'p','*' → opControl = 4'b1010, 'K'.
- 's' followed by 1000 idle cycles → 'T', nothing changed. A byte delivered at cycle 999 instead completes the frame normally.
- ipTxBusy held high for 100 cycles after a valid frame → opTxSend asserted exactly one cycle after busy falls. Two bytes strobed while waiting → two opDrop pulses, registers untouched.
- ipReset asserted after 'f','1',0x12 → all outputs at reset values. Subsequent 'x','0' → 'K', parsed as a fresh frame.

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-level link between the UART2 rx/tx pair and the command decoder.
// The master side is the UART; the slave side is the decoder.
interface uart_cmd_ctrl_if;
  logic [7:0] ipRxData;
  logic       ipRxValid;
  logic [7:0] opTxData;
  logic       opTxSend;
  logic       ipTxBusy;

  modport master (
    output ipRxData,
    output ipRxValid,
    output ipTxBusy,
    input  opTxData,
    input  opTxSend
  );

  modport slave (
    input  ipRxData,
    input  ipRxValid,
    input  ipTxBusy,
    output opTxData,
    output opTxSend
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Framed UART command decoder driving per-channel DAC control and
// frequency words, answering each frame with a one-byte status.
module uart_cmd_ctrl #(
  parameter int NUM_CH       = 2,
  parameter int FREQ_W       = 8,
  parameter int FREQ_DEFAULT = 108,
  parameter int TIMEOUT_CYC  = 1_000_000
) (
  input  logic                     ipClk,
  input  logic                     ipReset,
  uart_cmd_ctrl_if.slave           uart,
  output logic [2*NUM_CH-1:0]      opControl,
  output logic [FREQ_W*NUM_CH-1:0] opFreq,
  output logic                     opDrop
);
  localparam int FREQ_BYTES = FREQ_W / 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W = (FREQ_BYTES > 1) ? $clog2(FREQ_BYTES) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BC_W-1:0]   BC_LAST = BC_W'(FREQ_BYTES - 1);
  localparam logic [FREQ_W-1:0] F_RST   = FREQ_W'(FREQ_DEFAULT);

  localparam logic [7:0] R_OK  = 8'h4B;
  localparam logic [7:0] R_ERR = 8'h45;
  localparam logic [7:0] R_TO  = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_CH,
    S_GET_DATA,
    S_APPLY,
    S_RESP
  } state_t;

  state_t                     state_q, state_d;
  logic [TO_W-1:0]            to_q, to_d;
  logic [FREQ_W-1:0]          acc_q, acc_d;
  logic [BC_W-1:0]            bcnt_q, bcnt_d;
  logic [1:0]                 code_q, code_d;
  logic                       is_f_q, is_f_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic                       bcast_q, bcast_d;
  logic [7:0]                 resp_q, resp_d;
  logic [2*NUM_CH-1:0]        ctrl_q, ctrl_d;
  logic [FREQ_W*NUM_CH-1:0]   freq_q, freq_d;
  logic [7:0]                 tx_data_q, tx_data_d;
  logic                       tx_send_q, tx_send_d;
  logic                       drop_q, drop_d;

  logic [7:0] rx_off;
  logic       is_digit;
  logic       frame_ok;

  assign rx_off   = uart.ipRxData - 8'h30;
  assign is_digit = rx_off < 8'(NUM_CH);
  assign frame_ok = !(is_f_q && acc_q == '0);

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    acc_d     = acc_q;
    bcnt_d    = bcnt_q;
    code_d    = code_q;
    is_f_d    = is_f_q;
    ch_d      = ch_q;
    bcast_d   = bcast_q;
    resp_d    = resp_q;
    ctrl_d    = ctrl_q;
    freq_d    = freq_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    drop_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (uart.ipRxValid) begin
          to_d    = '0;
          acc_d   = '0;
          bcnt_d  = '0;
          is_f_d  = 1'b0;
          state_d = S_GET_CH;
          case (uart.ipRxData)
            8'h73:   code_d = 2'b01;
            8'h70:   code_d = 2'b10;
            8'h78:   code_d = 2'b00;
            8'h66:   is_f_d = 1'b1;
            default: begin
              resp_d  = R_ERR;
              state_d = S_RESP;
            end
          endcase
        end
      end

      S_GET_CH: begin
        if (uart.ipRxValid) begin
          to_d = '0;
          if (is_digit || uart.ipRxData == 8'h2A) begin
            ch_d    = rx_off[CH_W-1:0];
            bcast_d = !is_digit;
            state_d = is_f_q ? S_GET_DATA : S_APPLY;
          end else begin
            resp_d  = R_ERR;
            state_d = S_RESP;
          end
        end else if (to_q == TO_LAST) begin
          resp_d  = R_TO;
          state_d = S_RESP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_GET_DATA: begin
        if (uart.ipRxValid) begin
          to_d   = '0;
          acc_d  = (acc_q << 8) | FREQ_W'(uart.ipRxData);
          bcnt_d = bcnt_q + BC_W'(1);
          if (bcnt_q == BC_LAST) state_d = S_APPLY;
        end else if (to_q == TO_LAST) begin
          resp_d  = R_TO;
          state_d = S_RESP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_APPLY: begin
        drop_d = uart.ipRxValid;
        resp_d = frame_ok ? R_OK : R_ERR;
        if (frame_ok) begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (bcast_q || ch_q == CH_W'(n)) begin
              if (is_f_q) freq_d[FREQ_W*n +: FREQ_W] = acc_q;
              else        ctrl_d[2*n +: 2]           = code_q;
            end
          end
        end
        // Issue straight from APPLY when the transmitter is free.
        if (!uart.ipTxBusy) begin
          tx_send_d = 1'b1;
          tx_data_d = resp_d;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        drop_d = uart.ipRxValid;
        if (!uart.ipTxBusy) begin
          tx_send_d = 1'b1;
          tx_data_d = resp_q;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q   <= S_IDLE;
      to_q      <= '0;
      acc_q     <= '0;
      bcnt_q    <= '0;
      code_q    <= '0;
      is_f_q    <= 1'b0;
      ch_q      <= '0;
      bcast_q   <= 1'b0;
      resp_q    <= '0;
      ctrl_q    <= '0;
      freq_q    <= {NUM_CH{F_RST}};
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      acc_q     <= acc_d;
      bcnt_q    <= bcnt_d;
      code_q    <= code_d;
      is_f_q    <= is_f_d;
      ch_q      <= ch_d;
      bcast_q   <= bcast_d;
      resp_q    <= resp_d;
      ctrl_q    <= ctrl_d;
      freq_q    <= freq_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      drop_q    <= drop_d;
    end
  end

  assign uart.opTxData = tx_data_q;
  assign uart.opTxSend = tx_send_q;
  assign opControl     = ctrl_q;
  assign opFreq        = freq_q;
  assign opDrop        = drop_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomised scoreboard bench for uart_cmd_ctrl against a frame-level
// model of the command rules.
module tb_uart_cmd_ctrl;
  localparam int NUM_CH       = 2;
  localparam int FREQ_W       = 16;
  localparam int FB           = FREQ_W / 8;
  localparam int FREQ_DEFAULT = 108;
  localparam int TIMEOUT_CYC  = 1000;

  localparam logic [7:0] C_S = 8'h73;
  localparam logic [7:0] C_P = 8'h70;
  localparam logic [7:0] C_X = 8'h78;
  localparam logic [7:0] C_F = 8'h66;
  localparam logic [7:0] C_ALL = 8'h2A;
  localparam logic [7:0] R_K = 8'h4B;
  localparam logic [7:0] R_E = 8'h45;
  localparam logic [7:0] R_T = 8'h54;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if u ();
  logic [2*NUM_CH-1:0]      ctrl;
  logic [FREQ_W*NUM_CH-1:0] freq;
  logic                     drop;

  uart_cmd_ctrl #(
    .NUM_CH(NUM_CH),
    .FREQ_W(FREQ_W),
    .FREQ_DEFAULT(FREQ_DEFAULT),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .ipClk(clk),
    .ipReset(rst),
    .uart(u.slave),
    .opControl(ctrl),
    .opFreq(freq),
    .opDrop(drop)
  );

  typedef struct {
    logic [7:0]               resp;
    logic [2*NUM_CH-1:0]      ctrl;
    logic [FREQ_W*NUM_CH-1:0] freq;
    int                       at;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_c = 0;
  int exp_drops = 0;
  int act_drops = 0;
  logic prev_busy = 1'b0;

  logic [1:0]        ctrl_m[NUM_CH];
  logic [FREQ_W-1:0] freq_m[NUM_CH];
  logic [7:0]        fr[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [2*NUM_CH-1:0] pack_ctrl();
    logic [2*NUM_CH-1:0] v;
    for (int n = 0; n < NUM_CH; n++) v[2*n +: 2] = ctrl_m[n];
    return v;
  endfunction

  function automatic logic [FREQ_W*NUM_CH-1:0] pack_freq();
    logic [FREQ_W*NUM_CH-1:0] v;
    for (int n = 0; n < NUM_CH; n++) v[FREQ_W*n +: FREQ_W] = freq_m[n];
    return v;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      ctrl_m[n] = 2'b00;
      freq_m[n] = FREQ_W'(FREQ_DEFAULT);
    end
  endtask

  // Applies one frame's rules to the model; also reports how many bytes
  // of the frame the decoder will actually consume.
  task automatic model(input logic [7:0] f[$], output logic [7:0] resp,
                       output int used);
    int idx;
    int val;
    bit all;
    logic [1:0] code;
    if (!(f[0] inside {C_S, C_P, C_X, C_F})) begin
      resp = R_E; used = 1; return;
    end
    all = (f[1] == C_ALL);
    idx = int'(f[1]) - 48;
    if (!all && (idx < 0 || idx >= NUM_CH)) begin
      resp = R_E; used = 2; return;
    end
    resp = R_K;
    if (f[0] == C_F) begin
      used = 2 + FB;
      val = 0;
      for (int b = 0; b < FB; b++) val = val * 256 + int'(f[2+b]);
      if (val == 0) begin
        resp = R_E; return;
      end
      for (int n = 0; n < NUM_CH; n++)
        if (all || n == idx) freq_m[n] = FREQ_W'(val);
    end else begin
      used = 2;
      code = (f[0] == C_S) ? 2'b01 : (f[0] == C_P) ? 2'b10 : 2'b00;
      for (int n = 0; n < NUM_CH; n++)
        if (all || n == idx) ctrl_m[n] = code;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    u.ipRxData  = b;
    u.ipRxValid = 1'b1;
    last_c      = cyc;
    tick();
    u.ipRxValid = 1'b0;
  endtask

  task automatic send_frame(input int busy_hold, input int gap1);
    logic [7:0] resp;
    int used;
    int g;
    exp_t e;
    model(fr, resp, used);
    for (int i = 0; i < used; i++) begin
      if (i > 0) begin
        g = (i == 1 && gap1 >= 0) ? gap1 : int'($urandom_range(0, 3));
        repeat (g) tick();
      end
      if (i == used - 1 && busy_hold > 0) u.ipTxBusy = 1'b1;
      send_byte(fr[i]);
    end
    e.resp = resp;
    e.ctrl = pack_ctrl();
    e.freq = pack_freq();
    e.at   = (busy_hold > 0) ? last_c + busy_hold + 1 : last_c + 2;
    sbq.push_back(e);
    if (busy_hold > 0) begin
      for (int k = 1; k < busy_hold; k++) begin
        if (k == 10 || k == 20) begin
          u.ipRxData  = 8'($urandom);
          u.ipRxValid = 1'b1;
          exp_drops++;
        end
        tick();
        u.ipRxValid = 1'b0;
      end
      u.ipTxBusy = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sbq.size() != 0 && k < 3000) begin
      tick();
      k++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL resp_wait actual=no_send required=%0d_pending",
               sbq.size());
      sbq.delete();
    end
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_ctrl"}, 64'(ctrl), 64'(0));
    chk({tag, "_freq"}, 64'(freq),
        64'({NUM_CH{FREQ_W'(FREQ_DEFAULT)}}));
    chk({tag, "_send"}, 64'(u.opTxSend), 64'(0));
    chk({tag, "_txdata"}, 64'(u.opTxData), 64'(0));
    chk({tag, "_drop"}, 64'(drop), 64'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (u.opTxSend) begin
        chk("busy_guard", 64'(prev_busy), 64'(0));
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_send actual=%0h required=none", u.opTxData);
        end else begin
          e = sbq.pop_front();
          chk("resp", 64'(u.opTxData), 64'(e.resp));
          chk("ctrl", 64'(ctrl), 64'(e.ctrl));
          chk("freq", 64'(freq), 64'(e.freq));
          if (e.at >= 0) chk("send_cycle", 64'(cyc), 64'(e.at));
        end
      end
      if (drop) act_drops++;
    end
    prev_busy = u.ipTxBusy;
  end

  initial begin
    exp_t e;
    int r;
    u.ipRxData  = 8'h00;
    u.ipRxValid = 1'b0;
    u.ipTxBusy  = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs("init");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    fr = '{C_S, 8'h31};               send_frame(0, -1); wait_idle();
    fr = '{C_F, 8'h30, 8'h00, 8'h2A}; send_frame(0, -1); wait_idle();
    fr = '{C_F, 8'h30, 8'h00, 8'h00}; send_frame(0, -1); wait_idle();
    fr = '{8'h7A};                    send_frame(0, -1); wait_idle();
    fr = '{C_S, 8'h39};               send_frame(0, -1); wait_idle();
    fr = '{C_P, C_ALL};               send_frame(0, -1); wait_idle();

    // Inter-byte timeout, then a second byte just inside the window.
    send_byte(C_S);
    e.resp = R_T;
    e.ctrl = pack_ctrl();
    e.freq = pack_freq();
    e.at   = -1;
    sbq.push_back(e);
    wait_idle();
    fr = '{C_X, 8'h31};               send_frame(0, TIMEOUT_CYC - 2);
    wait_idle();

    fr = '{C_S, 8'h30};               send_frame(100, -1); wait_idle();

    send_byte(C_F);
    send_byte(8'h31);
    send_byte(8'h12);
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    fr = '{C_X, 8'h30};               send_frame(0, -1); wait_idle();

    for (int i = 0; i < 40; i++) begin
      fr.delete();
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        fr.push_back((r < 2) ? C_S : (r < 3) ? C_P : (r < 4) ? C_X : C_F);
      end else begin
        do fr.push_back(8'($urandom)); while (0);
        while (fr[0] inside {C_S, C_P, C_X, C_F}) fr[0] = 8'($urandom);
      end
      r = int'($urandom_range(0, 19));
      if (r < 14)      fr.push_back(8'(8'h30 + $urandom_range(0, NUM_CH - 1)));
      else if (r < 17) fr.push_back(C_ALL);
      else             fr.push_back(8'(8'h30 + $urandom_range(NUM_CH, 9)));
      r = int'($urandom_range(0, 6));
      for (int b = 0; b < FB; b++)
        fr.push_back((r == 0) ? 8'h00 : 8'($urandom));
      send_frame((i % 10 == 9) ? int'($urandom_range(25, 40)) : 0, -1);
      wait_idle();
    end

    chk("drop_count", 64'(act_drops), 64'(exp_drops));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
